// File: rtl/uart_frame_tx.sv
// UART transmitter: compile-time data width, run-time baud/parity/stop selection,
// ready/valid input that allows a new frame to start with no idle gap.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line high, waiting for send_en
// S_START  | start bit (0) for one bit period
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit, only when parity is enabled
// S_STOP   | one or two stop bits (1); may chain into S_START
module uart_frame_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] Data,
  input  logic                 send_en,
  input  logic [2:0]           baud_set,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 uart_tx,
  output logic                 tx_done
);

  // The slowest rate needs the widest counter.
  localparam int CW = $clog2(CLK_FREQ / 9600);

  localparam logic [CW-1:0] DIV_9600   = CW'(CLK_FREQ / 9600);
  localparam logic [CW-1:0] DIV_19200  = CW'(CLK_FREQ / 19200);
  localparam logic [CW-1:0] DIV_38400  = CW'(CLK_FREQ / 38400);
  localparam logic [CW-1:0] DIV_57600  = CW'(CLK_FREQ / 57600);
  localparam logic [CW-1:0] DIV_115200 = CW'(CLK_FREQ / 115200);
  localparam logic [CW-1:0] DIV_230400 = CW'(CLK_FREQ / 230400);
  localparam logic [CW-1:0] DIV_460800 = CW'(CLK_FREQ / 460800);
  localparam logic [CW-1:0] DIV_921600 = CW'(CLK_FREQ / 921600);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;

  logic [CW-1:0] div_sel;
  logic          bit_last;
  logic          final_stop;
  logic          accept;

  always_comb begin
    case (baud_set)
      3'd0:    div_sel = DIV_9600;
      3'd1:    div_sel = DIV_19200;
      3'd2:    div_sel = DIV_38400;
      3'd3:    div_sel = DIV_57600;
      3'd4:    div_sel = DIV_115200;
      3'd5:    div_sel = DIV_230400;
      3'd6:    div_sel = DIV_460800;
      default: div_sel = DIV_921600;
    endcase
  end

  always_comb begin
    bit_last   = (cnt_q == div_q - CW'(1));
    final_stop = (state_q == S_STOP) && bit_last && (bit_q == {3'b000, stop2_q});
    tx_done    = final_stop;
    tx_ready   = !Reset && ((state_q == S_IDLE) || final_stop);
    busy       = (state_q != S_IDLE);
    accept     = send_en && tx_ready;
    uart_tx    = tx_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_last ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;

    case (state_q)
      S_IDLE: cnt_d = '0;
      S_START: begin
        if (bit_last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_last) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (final_stop) begin
          state_d = S_IDLE;
          bit_d   = '0;
        end else if (bit_last) begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the end of the stop bit, giving gap-free chaining.
    if (accept) begin
      state_d   = S_START;
      cnt_d     = '0;
      bit_d     = '0;
      shift_d   = Data;
      div_d     = div_sel;
      par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d = (^Data) ^ (parity_mode == 2'b01);
      stop2_d   = stop2;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART transmitter, successor to the fixed 8N1 byte transmitter. Serialises one character per handshake with compile-time data width, run-time selectable parity and stop-bit count, an 8-entry baud table derived from the clock frequency, and a ready/valid handshake that supports gap-free back-to-back frames. Sits between user logic and the board `uart_tx` pin.

## Interface
- `CLK_FREQ`, 50_000_000, `Clk` frequency in Hz; bit divisors are computed from it at elaboration.
- `DATA_BITS`, 8, character width; legal range 5..9.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Data`  in  DATA_BITS  character to send, sent LSB first; sampled on accept.
- `send_en`  in  1  valid; a character is accepted on an edge where `send_en && tx_ready`.
- `baud_set`  in  3  0:9600, 1:19200, 2:38400, 3:57600, 4:115200, 5:230400, 6:460800, 7:921600; sampled on accept.
- `parity_mode`  in  2  00 none, 01 odd, 10 even, 11 none; sampled on accept.
- `stop2`  in  1  0: one stop bit, 1: two stop bits; sampled on accept.
- `tx_ready`  out  1  the block can accept a character this cycle.
- `busy`  out  1  a frame is in progress.
- `uart_tx`  out  1  serial line; idle high; registered.
- `tx_done`  out  1  one-cycle pulse marking the end of a frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA after 1 bit period.
  - DATA -> PARITY, or -> STOP if parity is none, after DATA_BITS bit periods.
  - PARITY -> STOP after 1 bit period.
  - STOP -> IDLE after 1 or 2 bit periods, or -> START directly if a new character is accepted in the final cycle.
- On accept, latch `Data`, the `baud_set` divisor, `parity_mode` and `stop2`. Input changes mid-frame have no effect.
- Bit period `DIV = CLK_FREQ / baud`, integer truncated; at 50 MHz: 5208, 2604, 1302, 868, 434, 217, 108, 54. The period counter runs 0..DIV-1 and its width comes from the 9600 entry.
- Parity: even = XOR of all data bits; odd = inverted XOR.
- Line levels: start bit 0, data bits LSB first, parity bit, stop bit(s) 1.
- `tx_ready` = (state == IDLE) or (last cycle of the final stop bit), and is forced 0 while `Reset` is high.
- `busy` = (state != IDLE).
- `tx_done` is high in the last clock cycle of the final stop bit only.

## Timing
- Reset values: `uart_tx` = 1, `tx_done` = 0, `busy` = 0, state IDLE, all counters 0. `tx_ready` = 1 from the first cycle after `Reset` deasserts.
- Accept at edge k: `uart_tx` goes 0 from cycle k+1, and `tx_done` is high in cycle k + N·DIV.
- N = 1 + DATA_BITS + (parity ? 1 : 0) + (stop2 ? 2 : 1).
- Back-to-back: if `send_en` is high during the `tx_done` cycle, the next start bit begins on the following cycle, so the line sees no extra idle cycles.
- `send_en` is ignored while `tx_ready` = 0; nothing is queued.
- Reset mid-frame: on the next edge `uart_tx` = 1 and the state returns to IDLE. No `tx_done` is generated and the latched character is discarded.
- Reset and accept on the same edge: reset wins and no frame starts.

## Test plan
- CLK_FREQ = 50e6, DATA_BITS = 8, baud_set = 4, parity none, stop2 = 0, Data = 8'hAB:
  - line sequence 0,1,1,0,1,0,1,0,1,1, each bit held 434 cycles;
  - `tx_done` high exactly 4340 cycles after accept;
  - `busy` high throughout the frame.
- Data = 8'h2E, baud_set = 4, stop2 = 1:
  - parity even -> parity bit 0; parity odd -> parity bit 1;
  - frame is 12 bits, `tx_done` at 5208 cycles.
- `send_en` held high with Data 8'h55 then 8'hA5:
  - the second start bit falls on the cycle right after the first `tx_done`;
  - no idle cycles between frames; exactly two `tx_done` pulses.
- baud_set = 7: bit period = 54 cycles. Changing `baud_set` to 0 mid-frame does not alter the current frame's bit period.
- `Reset` pulsed high for 1 cycle at the 3rd data bit:
  - `uart_tx` is 1 on the next cycle;
  - no `tx_done`;
  - `tx_ready` = 1 afterwards, and a fresh 8'hAB frame then transmits correctly.
- DATA_BITS = 7, even parity, Data = 7'h41: parity bit 0, frame 10 bits, `tx_done` at 4340 cycles for baud_set = 4.
